// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and width helpers for the SPI master slice.
//            FSM state encoding, per-transaction SPI mode and the functions
//            that size the length, chip-select index and prescale counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of an index/counter over n values, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold a bit count in the range 0..dw inclusive.
  function automatic int len_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_gen
// Purpose  : Half-period prescaler for the SPI master. Counts PRESCALER/2
//            system clocks while enabled and flags the last cycle of every
//            half-period. A phase bit alternates on each tick so the master
//            knows whether the next SCLK edge is leading or trailing.
// Ports    : clock_in  - system clock
//            reset_in  - synchronous active-low reset
//            i_enable  - run the counter (low clears counter and phase)
//            o_tick    - last cycle of a half-period
//            o_leading - the edge produced by the current tick is leading
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int PRESCALER = 10
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic i_enable,
  output logic o_tick,
  output logic o_leading
);

  localparam int c_HALF = PRESCALER / 2;
  localparam int c_CW   = idx_width(c_HALF);

  logic [c_CW-1:0] r_cnt;
  logic            r_phase;
  logic            w_last;

  assign w_last    = (r_cnt == c_CW'(c_HALF - 1));
  assign o_tick    = i_enable && w_last;
  assign o_leading = ~r_phase;

  // Disabling restarts the count so every transaction begins on a clean
  // half-period boundary with the first edge marked as leading.
  always_ff @(posedge clock_in) begin
    if (!reset_in || !i_enable) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_last) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Full-duplex MSB-first SPI master with per-transaction CPOL/CPHA,
//            variable bit count (1..DATA_WIDTH) and NUM_CS active-low selects.
//            Sequence: SETUP (H) -> TRANSFER (2N half-periods) -> HOLD (H),
//            then a one-cycle done pulse with the received word.
// Ports    : clock_in, reset_in (sync, active-low)
//            data_in, data_length_in, cs_select_in, cpol_in, cpha_in
//                         - transaction config, latched on accepted start
//            start_in     - request, accepted only when idle
//            loopback_in  - (SPI_LOOPBACK_EN only) sample internal MOSI
//            miso_in      - serial data from peripheral
//            busy_out, done_out, data_out - status and received word
//            sclk_out, mosi_out, cs_out   - SPI pins
// Macro    : SPI_LOOPBACK_EN adds the loopback_in port.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PRESCALER  = 10,
  parameter int NUM_CS     = 2
) (
  input  logic                               clock_in,
  input  logic                               reset_in,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic [len_width(DATA_WIDTH)-1:0]   data_length_in,
  input  logic [idx_width(NUM_CS)-1:0]       cs_select_in,
  input  logic                               cpol_in,
  input  logic                               cpha_in,
  input  logic                               start_in,
`ifdef SPI_LOOPBACK_EN
  input  logic                               loopback_in,
`endif
  input  logic                               miso_in,
  output logic                               busy_out,
  output logic                               done_out,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               sclk_out,
  output logic                               mosi_out,
  output logic [NUM_CS-1:0]                  cs_out
);

  localparam int c_LW = len_width(DATA_WIDTH);
  localparam int c_SW = idx_width(NUM_CS);
  localparam int c_EW = c_LW + 1;

  spi_state_t            r_state;
  spi_state_t            w_next;
  spi_mode_t             w_mode;
  logic                  r_cpha;
  logic [c_LW-1:0]       w_len;
  logic [c_LW-1:0]       r_len;
  logic [c_EW-1:0]       r_edges;
  logic [DATA_WIDTH-1:0] w_aligned;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [NUM_CS-1:0]     w_cs_dec;
  logic [NUM_CS-1:0]     r_cs;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  w_bit;
  logic                  w_tick;
  logic                  w_leading;
  logic                  w_accept;
  logic                  w_edge;
  logic                  w_sample;
  logic                  w_finish;

  spi_clk_gen #(
    .PRESCALER (PRESCALER)
  ) u_clk_gen (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .i_enable  (r_state != IDLE),
    .o_tick    (w_tick),
    .o_leading (w_leading)
  );

  assign w_mode = '{cpol: cpol_in, cpha: cpha_in};

  // Oversized bit counts are clamped to the full word.
  assign w_len = (data_length_in > c_LW'(DATA_WIDTH)) ? c_LW'(DATA_WIDTH)
                                                      : data_length_in;

  // Left-align the right-aligned word so bit N-1 always sits at the MSB.
  assign w_aligned = data_in << (c_LW'(DATA_WIDTH) - w_len);

  assign w_accept = (r_state == IDLE) && start_in && (w_len != '0);

  // The SETUP tick produces edge 1; TRANSFER ticks produce edges 2..2N and
  // the tick ending the final half-period only moves on to HOLD.
  assign w_edge   = w_tick && ((r_state == SETUP) ||
                    ((r_state == TRANSFER) && (r_edges != {r_len, 1'b0})));
  assign w_sample = w_edge && (w_leading ^ r_cpha);
  assign w_finish = w_tick && (r_state == HOLD);

  // Out-of-range indices leave every select deasserted.
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_select_in == c_SW'(i)) begin
        w_cs_dec[i] = 1'b0;
      end
    end
  end

`ifdef SPI_LOOPBACK_EN
  logic r_loop;

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      r_loop <= 1'b0;
    end else if (w_accept) begin
      r_loop <= loopback_in;
    end
  end

  // r_mosi holds the bit on the wire at every sample edge in both phases.
  assign w_bit = r_loop ? r_mosi : miso_in;
`else
  assign w_bit = miso_in;
`endif

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = SETUP;
      SETUP:    if (w_tick) w_next = TRANSFER;
      TRANSFER: if (w_tick && (r_edges == {r_len, 1'b0})) w_next = HOLD;
      HOLD:     if (w_tick) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      r_cpha  <= 1'b0;
      r_len   <= '0;
      r_edges <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_cs    <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_cpha  <= w_mode.cpha;
        r_len   <= w_len;
        r_edges <= '0;
        r_rx    <= '0;
        r_cs    <= w_cs_dec;
        r_busy  <= 1'b1;
        r_sclk  <= w_mode.cpol;
        // CPHA=0 presents the first bit before the first edge; CPHA=1
        // waits for the leading edge to drive it.
        if (!w_mode.cpha) begin
          r_mosi <= w_aligned[DATA_WIDTH-1];
          r_tx   <= w_aligned << 1;
        end else begin
          r_tx   <= w_aligned;
        end
      end

      if (w_edge) begin
        r_sclk  <= ~r_sclk;
        r_edges <= r_edges + c_EW'(1);
        if (w_sample) begin
          r_rx <= DATA_WIDTH'({r_rx, w_bit});
        end else begin
          r_mosi <= r_tx[DATA_WIDTH-1];
          r_tx   <= r_tx << 1;
        end
      end

      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_cs   <= '1;
        r_dout <= r_rx;
        r_mosi <= 1'b0;
      end
    end
  end

  assign busy_out = r_busy;
  assign done_out = r_done;
  assign data_out = r_dout;
  assign sclk_out = r_sclk;
  assign mosi_out = r_mosi;
  assign cs_out   = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench for spi_master (DATA_WIDTH=16,
//            PRESCALER=10, NUM_CS=2). A sampled SPI slave model drives MISO
//            and captures MOSI; expected results are queued at each start
//            and checked when done_out pulses.
// Macro    : SPI_LOOPBACK_EN enables the loopback transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  `define CHK(TAG, OBS, EXP) \
    begin \
      n_chk++; \
      assert ((OBS) === (EXP)) else begin \
        n_err++; \
        $error("FAIL %s: observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
      end \
    end

  typedef struct {
    logic [15:0] data;
    logic [15:0] tx;
    int          blen;
    logic [1:0]  cs;
    logic        cpol;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic [15:0] data_in = '0;
  logic [4:0]  data_length_in = '0;
  logic        cs_select_in = 1'b0;
  logic        cpol_in = 1'b0;
  logic        cpha_in = 1'b0;
  logic        start_in = 1'b0;
  logic        loopback_in = 1'b0;
  logic        miso_in = 1'b0;
  logic        busy_out;
  logic        done_out;
  logic [15:0] data_out;
  logic        sclk_out;
  logic        mosi_out;
  logic [1:0]  cs_out;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int exp_done = 0;
  exp_t q[$];

  // slave model state
  logic [15:0] s_word = '0;
  logic [15:0] s_rx = '0;
  int          s_n = 1;
  int          s_idx = 0;
  logic        s_cpol = 1'b0;
  logic        s_cpha = 1'b0;
  logic        s_en = 1'b1;

  // monitor state
  logic prev_act = 1'b0;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic act;
  logic lead;
  logic [1:0] cs_seen = 2'b11;
  int   busy_cnt = 0;
  int   mosi_bad = 0;
  exp_t e;

  spi_master #(
    .DATA_WIDTH (16),
    .PRESCALER  (10),
    .NUM_CS     (2)
  ) dut (
    .clock_in       (clk),
    .reset_in       (reset_in),
    .data_in        (data_in),
    .data_length_in (data_length_in),
    .cs_select_in   (cs_select_in),
    .cpol_in        (cpol_in),
    .cpha_in        (cpha_in),
    .start_in       (start_in),
`ifdef SPI_LOOPBACK_EN
    .loopback_in    (loopback_in),
`endif
    .miso_in        (miso_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .data_out       (data_out),
    .sclk_out       (sclk_out),
    .mosi_out       (mosi_out),
    .cs_out         (cs_out)
  );

  always #5 clk = ~clk;

  // Slave model and scoreboard checker, sampling on the falling clock edge.
  always @(negedge clk) begin
    act = (cs_out != 2'b11);
    if (act && !prev_act) begin
      s_idx = s_n - 1;
      s_rx  = '0;
      if (!s_cpha) miso_in = s_en ? s_word[s_idx] : 1'b0;
    end else if (act && (sclk_out != prev_sclk)) begin
      lead = (sclk_out != s_cpol);
      if (lead == !s_cpha) begin
        s_rx = {s_rx[14:0], mosi_out};
        if (s_cpha) s_idx = s_idx - 1;
      end else begin
        if (!s_cpha) s_idx = s_idx - 1;
        if (s_idx >= 0) miso_in = s_en ? s_word[s_idx] : 1'b0;
      end
    end

    // MOSI may only move on the drive edge while a transfer is running.
    if (busy_out && prev_busy && (mosi_out != prev_mosi)) begin
      if (!((sclk_out != prev_sclk) && ((sclk_out != s_cpol) == s_cpha)))
        mosi_bad++;
    end

    if (busy_out) begin
      busy_cnt = prev_busy ? busy_cnt + 1 : 1;
      cs_seen  = cs_out;
    end

    if (done_out) begin
      n_done++;
      `CHK("done_single_cycle", prev_done, 1'b0)
      `CHK("done_expected", (q.size() > 0), 1'b1)
      if (q.size() > 0) begin
        e = q.pop_front();
        `CHK("data_out", data_out, e.data)
        `CHK("busy_cycles", busy_cnt, e.blen)
        `CHK("cs_during_busy", cs_seen, e.cs)
        `CHK("mosi_stream", s_rx, e.tx)
        `CHK("cs_released", cs_out, 2'b11)
        `CHK("busy_low_at_done", busy_out, 1'b0)
        `CHK("sclk_idle", sclk_out, e.cpol)
        `CHK("mosi_edge_ok", mosi_bad, 0)
      end
    end

    prev_act  = act;
    prev_sclk = sclk_out;
    prev_mosi = mosi_out;
    prev_busy = busy_out;
    prev_done = done_out;
  end

  task automatic run_txn(input logic [15:0] d, input logic [4:0] len,
                         input logic cs, input logic cpol, input logic cpha,
                         input logic [15:0] sw, input logic lb);
    int   n;
    logic [15:0] mask;
    exp_t x;
    n    = (len > 5'd16) ? 16 : int'(len);
    mask = (n == 16) ? 16'hFFFF : ((16'h1 << n) - 16'h1);
    @(posedge clk);
    #1;
    s_word = sw; s_n = n; s_cpol = cpol; s_cpha = cpha; s_en = !lb;
    data_in = d; data_length_in = len; cs_select_in = cs;
    cpol_in = cpol; cpha_in = cpha; loopback_in = lb;
    start_in = 1'b1;
    x.tx   = d & mask;
    x.data = lb ? (d & mask) : (sw & mask);
    x.blen = 5 * (2 * n + 2);
    x.cs   = cs ? 2'b01 : 2'b10;
    x.cpol = cpol;
    q.push_back(x);
    exp_done++;
    @(posedge clk);
    #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = n_done;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (n_done != d0) break;
    end
    `CHK("done_timeout", (n_done != d0), 1'b1)
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int busy_sum;
    int d0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_busy", busy_out, 1'b0)
    `CHK("rst_done", done_out, 1'b0)
    `CHK("rst_data", data_out, 16'h0000)
    `CHK("rst_sclk", sclk_out, 1'b0)
    `CHK("rst_mosi", mosi_out, 1'b0)
    `CHK("rst_cs", cs_out, 2'b11)
    reset_in = 1'b1;
    repeat (2) @(posedge clk);

    // mode 0, 16 bits
    run_txn(16'h3F3C, 5'd16, 1'b0, 1'b0, 1'b0, 16'hA55A, 1'b0);
    `CHK("busy_after_accept", busy_out, 1'b1)
    wait_done();

    // mode 3, 8 bits on cs 1
    run_txn(16'h00C3, 5'd8, 1'b1, 1'b1, 1'b1, 16'h005B, 1'b0);
    `CHK("mode3_cs1_low", cs_out, 2'b01)
    wait_done();
    `CHK("mode3_sclk_idle_high", sclk_out, 1'b1)

    // N=0 request is ignored
    @(posedge clk);
    #1;
    data_length_in = 5'd0; data_in = 16'hFFFF; start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    d0 = n_done;
    busy_sum = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy_out) busy_sum++;
    end
    `CHK("len0_no_busy", busy_sum, 0)
    `CHK("len0_no_done", n_done, d0)

    // mode 1, 12 bits, with an ignored start and config change mid-transfer
    run_txn(16'h0ABC, 5'd12, 1'b0, 1'b0, 1'b1, 16'h05A5, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    data_in = 16'hFFFF; data_length_in = 5'd4; cs_select_in = 1'b1;
    cpol_in = 1'b1; cpha_in = 1'b0; start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    `CHK("mid_start_still_busy", busy_out, 1'b1)
    `CHK("mid_start_cs_kept", cs_out, 2'b10)
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    `CHK("mid_start_no_second_txn", busy_out, 1'b0)

    // reset asserted mid-transfer
    run_txn(16'h1357, 5'd16, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0);
    repeat (59) @(posedge clk);
    #1;
    reset_in = 1'b0;
    @(posedge clk);
    #1;
    `CHK("abort_cs", cs_out, 2'b11)
    `CHK("abort_busy", busy_out, 1'b0)
    `CHK("abort_data", data_out, 16'h0000)
    `CHK("abort_done", done_out, 1'b0)
    `CHK("abort_sclk", sclk_out, 1'b0)
    reset_in = 1'b1;
    q.delete();
    exp_done--;
    d0 = n_done;
    repeat (20) @(posedge clk);
    `CHK("abort_no_done", n_done, d0)
    run_txn(16'h02AB, 5'd10, 1'b0, 1'b0, 1'b0, 16'h03C5, 1'b0);
    wait_done();

    // oversized length clamps to 16
    run_txn(16'hBEEF, 5'd20, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0);
    wait_done();

`ifdef SPI_LOOPBACK_EN
    run_txn(16'h1234, 5'd16, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    wait_done();
`endif

    `CHK("total_done", n_done, exp_done)
    `CHK("queue_empty", q.size(), 0)

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  `undef CHK

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
Parametrised full-duplex SPI master, successor to the team's fixed-mode, transmit-only SPI block. It adds a configurable word width, all four SPI modes (CPOL/CPHA selected per transaction), MISO capture and multiple chip selects. It sits between control FSMs (DAC/laser drivers, ADC readback) and off-chip SPI peripherals. Transfers are MSB-first with a variable bit count.

Parameters:
DATA_WIDTH, 16, maximum bits per transaction; width of data_in and data_out.
PRESCALER, 10, clock_in cycles per SCLK period; must be even and ≥2; half-period H = PRESCALER/2.
NUM_CS, 2, number of active-low chip-select lines.

Ports:
clock_in  in  1  system clock; single clock domain.
reset_in  in  1  synchronous, active-low reset.
data_in  in  DATA_WIDTH  transmit word, right-aligned; latched on start.
data_length_in  in  $clog2(DATA_WIDTH+1)  bit count N; latched on start.
cs_select_in  in  $clog2(NUM_CS) (min 1)  chip-select index; latched on start.
cpol_in  in  1  SCLK idle level; latched on start.
cpha_in  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on start.
start_in  in  1  level-sampled request; accepted only in IDLE.
miso_in  in  1  serial data from peripheral.
busy_out  out  1  high from the cycle after acceptance until the transaction ends.
done_out  out  1  one-cycle pulse at the end of the transaction.
data_out  out  DATA_WIDTH  received word, right-aligned, upper bits zero; held until the next done.
sclk_out  out  1  SPI clock.
mosi_out  out  1  serial data to peripheral.
cs_out  out  NUM_CS  active-low chip selects; only one is ever low.

Behaviour:
- Reset (reset_in=0 at a clock edge): FSM→IDLE; busy_out=0, done_out=0, data_out=0, sclk_out=0, mosi_out=0, cs_out=all 1. Reset mid-transfer aborts at that edge. No done pulse is produced, and data_out is cleared.
- IDLE: sclk_out holds the last latched CPOL (0 after reset). When start_in=1, latch all config. N is clamped to DATA_WIDTH. If N=0, the request is ignored: no busy, no done.
- SETUP, H cycles: busy=1; the selected cs goes low in the cycle after acceptance; sclk=CPOL. For CPHA=0, mosi = bit N-1 from the first SETUP cycle.
- TRANSFER, 2N half-periods of H cycles each; sclk toggles at every half-period boundary.
  - CPHA=0: sample miso_in on the leading edge; shift mosi on the trailing edge.
  - CPHA=1: drive mosi on the leading edge; sample on the trailing edge.
- HOLD, H cycles: sclk=CPOL; cs still low.
- Completion, in the last HOLD cycle +1: cs all high, busy=0, done_out=1 for one cycle, data_out updated in the same cycle. Return to IDLE. A new start is accepted the cycle after done.
- Total busy duration = H·(2N+2) cycles. Example: PRESCALER=10, N=16 gives 170 cycles.
- start_in while busy is ignored. Config input changes during busy have no effect.
- cs_select_in ≥ NUM_CS: no cs line asserts, but timing is unchanged and data_out captures miso_in.
- Sampling uses miso_in registered at the sample edge only; there is no synchroniser (peripheral is synchronous to SCLK).

Optional Feature:
Macro SPI_LOOPBACK_EN.
- Defined: adds input port loopback_in (1 bit). While the latched copy of loopback_in is 1, the sampled bit is taken from the internal mosi value instead of miso_in, so data_out equals data_in[N-1:0]. All pins behave normally.
- Undefined: the port is absent and sampling always uses miso_in.

Decomposition:
- Package spi_pkg: state enum (IDLE, SETUP, TRANSFER, HOLD); spi_mode_t struct {cpol, cpha}; localparam helpers for counter widths.
- Sub-module spi_clk_gen: H-cycle prescale counter, enabled while busy. Emits a half-period tick and a leading/trailing flag; the main FSM consumes the ticks.

Test Plan:
- Mode 0, PRESCALER=10, N=16, data_in=16'h3F3C, miso driven by a slave model returning 16'hA55A → mosi bitstream 0011111100111100 sampled on rising edges; busy high 170 cycles; done pulse once; data_out=16'hA55A; cs_out=2'b10.
- Mode 3 (CPOL=1, CPHA=1), N=8, data_in=8'hC3, cs_select_in=1 → sclk idles high; mosi changes on falling edges; data_out equals the slave's byte; cs_out=2'b01; busy 90 cycles.
- N=0 start, and start pulsed mid-transfer → no busy/done for N=0; the mid-transfer start is ignored and the original transaction completes unchanged.
- Reset (reset_in=0) asserted for one cycle at mid-transfer cycle 60 → next edge: cs all 1, busy 0, data_out 0, no done; a fresh start afterwards completes normally.
- N=20 with DATA_WIDTH=16 → clamped to 16 bits, busy 170 cycles.
- SPI_LOOPBACK_EN defined, loopback_in=1, data_in=16'h1234, miso_in tied 0 → data_out=16'h1234.
